// File: rtl/hazard_sequencer_if.sv
// Pipeline hazard control bundle: ID/EX hazard inputs plus pipeline enable/flush outputs.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; the sequencer's enables are the pipeline's backpressure.
//
// Ports (slave = sequencer side):
//   inputs : ID_rs1_i, ID_rs2_i, ID_use_rs1_i, ID_use_rs2_i, EXE_rd_i,
//            EXE_MemRead_i, EXE_branch_taken_i, EXE_md_valid_i
//   outputs: PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o,
//            IDEX_flush_o, EXMEM_bubble_o, md_done_o, stall_cycles_o
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs1_i;
    logic [4:0]       ID_rs2_i;
    logic             ID_use_rs1_i;
    logic             ID_use_rs2_i;
    logic [4:0]       EXE_rd_i;
    logic             EXE_MemRead_i;
    logic             EXE_branch_taken_i;
    logic             EXE_md_valid_i;
    logic             PC_write_o;
    logic             IFID_write_o;
    logic             IFID_flush_o;
    logic             IDEX_write_o;
    logic             IDEX_flush_o;
    logic             EXMEM_bubble_o;
    logic             md_done_o;
    logic [CNT_W-1:0] stall_cycles_o;

    // Pipeline side: drives hazard information, receives control.
    modport master (
        output ID_rs1_i, ID_rs2_i, ID_use_rs1_i, ID_use_rs2_i,
        output EXE_rd_i, EXE_MemRead_i, EXE_branch_taken_i, EXE_md_valid_i,
        input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o,
        input  IDEX_flush_o, EXMEM_bubble_o, md_done_o, stall_cycles_o
    );

    // Sequencer side.
    modport slave (
        input  ID_rs1_i, ID_rs2_i, ID_use_rs1_i, ID_use_rs2_i,
        input  EXE_rd_i, EXE_MemRead_i, EXE_branch_taken_i, EXE_md_valid_i,
        output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o,
        output IDEX_flush_o, EXMEM_bubble_o, md_done_o, stall_cycles_o
    );
endinterface

// File: rtl/hazard_sequencer.sv
// 5-stage pipeline hazard sequencer: load-use stall, EX branch flush, multi-cycle MUL/DIV hold.
// Latency: control outputs are combinational from state and inputs (zero cycles).
// Backpressure: drops PC/IFID/IDEX write enables to hold the pipeline; counts stalled cycles.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset; forces every output to 0 while low
//   hz     - hazard_sequencer_if.slave bundle (hazard inputs, pipeline control outputs)
module hazard_sequencer #(
    parameter int MD_LATENCY = 4,   // cycles a MUL/DIV occupies EX, 2..16
    parameter int CNT_W      = 16   // stall counter width
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_sequencer_if.slave  hz
);
    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // The RUN start cycle is the first EX cycle, and MD_BUSY spends one more
    // cycle at md_cnt == 0 to release the result, hence the -2.
    localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

    state_t           r_state;
    logic [3:0]       r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_md_stall;
    logic w_md_done;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_write;
    logic w_idex_flush;
    logic w_exmem_bubble;
    logic w_md_done_out;

    // x0 is hardwired zero, so a load "to x0" never creates a dependency.
    assign w_load_use = hz.EXE_MemRead_i & (hz.EXE_rd_i != 5'd0) &
                        ((hz.ID_use_rs1_i & (hz.EXE_rd_i == hz.ID_rs1_i)) |
                         (hz.ID_use_rs2_i & (hz.EXE_rd_i == hz.ID_rs2_i)));

    // md_valid only starts an operation from RUN; in the release cycle
    // (MD_BUSY, md_cnt == 0) the same instruction is still in EX and must
    // not restart.
    assign w_md_stall = ((r_state == RUN) && hz.EXE_md_valid_i) ||
                        ((r_state == MD_BUSY) && (r_md_cnt != 4'd0));
    assign w_md_done  = (r_state == MD_BUSY) && (r_md_cnt == 4'd0);

    always_comb begin
        w_pc_write     = 1'b0;
        w_ifid_write   = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_write   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_bubble = 1'b0;
        w_md_done_out  = 1'b0;
        if (!rst_i) begin
            // Reset freezes the pipeline: everything stays 0.
        end else if (w_md_stall) begin
            // Hold IF/ID/EX; MEM keeps draining with bubbles.
            w_exmem_bubble = 1'b1;
        end else begin
            w_pc_write    = 1'b1;
            w_ifid_write  = 1'b1;
            w_idex_write  = 1'b1;
            w_md_done_out = w_md_done;
            if (hz.EXE_branch_taken_i) begin
                // Dependent instruction in ID is flushed, so load-use is moot.
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (w_load_use) begin
                // One bubble suffices: next cycle the load is in MEM and
                // forwarding covers the dependency.
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= RUN;
            r_md_cnt    <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (hz.EXE_md_valid_i) begin
                        r_state  <= MD_BUSY;
                        r_md_cnt <= MD_INIT;
                    end
                end
                MD_BUSY: begin
                    if (r_md_cnt != 4'd0) begin
                        r_md_cnt <= r_md_cnt - 4'd1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase

            // Saturating: only a held PC is a lost cycle.
            if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.PC_write_o     = w_pc_write;
    assign hz.IFID_write_o   = w_ifid_write;
    assign hz.IFID_flush_o   = w_ifid_flush;
    assign hz.IDEX_write_o   = w_idex_write;
    assign hz.IDEX_flush_o   = w_idex_flush;
    assign hz.EXMEM_bubble_o = w_exmem_bubble;
    assign hz.md_done_o      = w_md_done_out;
    assign hz.stall_cycles_o = r_stall_cnt;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: three builds (LAT4/CNT16, LAT2/CNT16, LAT4/CNT4) on shared stimulus.
// Latency: outputs sampled 1 ns after the inputs change on the falling edge.
// Backpressure: n/a.
module tb_hazard_sequencer;
    // Output code order: pc, ifid_w, ifid_f, idex_w, idex_f, bubble, done
    typedef struct packed {
        logic [6:0]  code;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [6:0] C_ZERO   = 7'b0000000;
    localparam logic [6:0] C_DEF    = 7'b1101000;
    localparam logic [6:0] C_LU     = 7'b0001100;
    localparam logic [6:0] C_BR     = 7'b1111100;
    localparam logic [6:0] C_MD     = 7'b0000010;
    localparam logic [6:0] C_DONE   = 7'b1101001;
    localparam logic [6:0] C_DONEBR = 7'b1111101;
    localparam logic [6:0] C_DONELU = 7'b0001101;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memrd, br, md;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   exp_cnt_b = 0;
    exp_t exp_q[$];
    exp_t e;

    hazard_sequencer_if #(.CNT_W(16)) if_a ();
    hazard_sequencer_if #(.CNT_W(16)) if_b ();
    hazard_sequencer_if #(.CNT_W(4))  if_c ();

    hazard_sequencer #(.MD_LATENCY(4), .CNT_W(16)) u_a (.clk_i(clk), .rst_i(rst_n), .hz(if_a));
    hazard_sequencer #(.MD_LATENCY(2), .CNT_W(16)) u_b (.clk_i(clk), .rst_i(rst_n), .hz(if_b));
    hazard_sequencer #(.MD_LATENCY(4), .CNT_W(4))  u_c (.clk_i(clk), .rst_i(rst_n), .hz(if_c));

    assign if_a.ID_rs1_i = rs1;   assign if_b.ID_rs1_i = rs1;   assign if_c.ID_rs1_i = rs1;
    assign if_a.ID_rs2_i = rs2;   assign if_b.ID_rs2_i = rs2;   assign if_c.ID_rs2_i = rs2;
    assign if_a.ID_use_rs1_i = use1; assign if_b.ID_use_rs1_i = use1; assign if_c.ID_use_rs1_i = use1;
    assign if_a.ID_use_rs2_i = use2; assign if_b.ID_use_rs2_i = use2; assign if_c.ID_use_rs2_i = use2;
    assign if_a.EXE_rd_i = rd;    assign if_b.EXE_rd_i = rd;    assign if_c.EXE_rd_i = rd;
    assign if_a.EXE_MemRead_i = memrd; assign if_b.EXE_MemRead_i = memrd; assign if_c.EXE_MemRead_i = memrd;
    assign if_a.EXE_branch_taken_i = br; assign if_b.EXE_branch_taken_i = br; assign if_c.EXE_branch_taken_i = br;
    assign if_a.EXE_md_valid_i = md; assign if_b.EXE_md_valid_i = md; assign if_c.EXE_md_valid_i = md;

    exp_t obs_a, obs_b, obs_c;
    assign obs_a = {if_a.PC_write_o, if_a.IFID_write_o, if_a.IFID_flush_o, if_a.IDEX_write_o,
                    if_a.IDEX_flush_o, if_a.EXMEM_bubble_o, if_a.md_done_o, if_a.stall_cycles_o};
    assign obs_b = {if_b.PC_write_o, if_b.IFID_write_o, if_b.IFID_flush_o, if_b.IDEX_write_o,
                    if_b.IDEX_flush_o, if_b.EXMEM_bubble_o, if_b.md_done_o, if_b.stall_cycles_o};
    assign obs_c = {if_c.PC_write_o, if_c.IFID_write_o, if_c.IFID_flush_o, if_c.IDEX_write_o,
                    if_c.IDEX_flush_o, if_c.EXMEM_bubble_o, if_c.md_done_o, 12'd0, if_c.stall_cycles_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lu: 0 none, 1 rs2 match, 2 match on x0, 3 rs1 match,
    //     4 match but no use flags, 5 match but not a load
    task automatic drive(input logic i_md, input logic i_br, input int lu);
        md = i_md; br = i_br;
        rs1 = 5'd1; rs2 = 5'd2; use1 = 1'b1; use2 = 1'b1; rd = 5'd9; memrd = 1'b0;
        case (lu)
            1: begin memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; use1 = 1'b0; end
            2: begin memrd = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; end
            3: begin memrd = 1'b1; rd = 5'd7; rs1 = 5'd7; use2 = 1'b0; end
            4: begin memrd = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd5; use1 = 1'b0; use2 = 1'b0; end
            5: begin rd = 5'd5; rs2 = 5'd5; end
            default: ;
        endcase
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst_n = 1'b0; drive(1'b0, 1'b0, 0);
        @(negedge clk); rst_n = 1'b1;
        exp_cnt = 0; exp_cnt_b = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drive(1'b0, 1'b0, 0);
        @(negedge clk); #1;
        exp_q.push_back({C_ZERO, 16'd0});
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL reset_a got %h exp %h", obs_a, e); end
        checks++;
        if (obs_c !== e) begin errors++; $display("FAIL reset_c got %h exp %h", obs_c, e); end
        @(negedge clk); rst_n = 1'b1; exp_cnt = 0; exp_cnt_b = 0;
    endtask

    task automatic test_defaults();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); drive(1'b0, 1'b0, 0);
            exp_q.push_back({C_DEF, 16'(exp_cnt)});
            #1; e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL defaults cyc %0d got %h exp %h", k, obs_a, e); end
        end
    endtask

    task automatic test_load_use();
        int         lu_t[7]   = '{1, 0, 2, 3, 0, 4, 5};
        logic [6:0] code_t[7] = '{C_LU, C_DEF, C_DEF, C_LU, C_DEF, C_DEF, C_DEF};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); drive(1'b0, 1'b0, lu_t[k]);
            exp_q.push_back({code_t[k], 16'(exp_cnt)});
            #1; e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL load_use cyc %0d got %h exp %h", k, obs_a, e); end
            if (!e.code[6]) exp_cnt++;
        end
    endtask

    task automatic test_branch_over_load_use();
        logic       br_t[2]   = '{1'b1, 1'b0};
        int         lu_t[2]   = '{1, 0};
        logic [6:0] code_t[2] = '{C_BR, C_DEF};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); drive(1'b0, br_t[k], lu_t[k]);
            exp_q.push_back({code_t[k], 16'(exp_cnt)});
            #1; e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL branch_lu cyc %0d got %h exp %h", k, obs_a, e); end
            if (!e.code[6]) exp_cnt++;
        end
    endtask

    // Two back-to-back 4-cycle ops; hazards during the hold are ignored,
    // hazards during the release cycle are honoured.
    task automatic test_back_to_back();
        logic       md_t[9]   = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic       br_t[9]   = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
        int         lu_t[9]   = '{0, 1, 0, 1, 0, 0, 0, 1, 0};
        logic [6:0] code_t[9] = '{C_MD, C_MD, C_MD, C_DONELU, C_MD, C_MD, C_MD, C_DONEBR, C_DEF};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); drive(md_t[k], br_t[k], lu_t[k]);
            exp_q.push_back({code_t[k], 16'(exp_cnt)});
            #1; e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL muldiv cyc %0d got %h exp %h", k, obs_a, e); end
            if (!e.code[6]) exp_cnt++;
        end
    endtask

    task automatic test_reset_mid_md();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1'b1, 1'b0, 0);
            exp_q.push_back({C_MD, 16'(exp_cnt)});
            #1; e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL md_prereset cyc %0d got %h exp %h", k, obs_a, e); end
            exp_cnt++;
        end
        // md_cnt is 1 here; drop reset between clock edges.
        #1 rst_n = 1'b0; exp_cnt = 0; exp_cnt_b = 0;
        exp_q.push_back({C_ZERO, 16'd0});
        #1; e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL async_reset got %h exp %h", obs_a, e); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drive(1'b0, 1'b0, 0); rst_n = 1'b1;
            exp_q.push_back({C_DEF, 16'(exp_cnt)});
            #1; e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL post_reset cyc %0d got %h exp %h", k, obs_a, e); end
        end
    endtask

    task automatic test_md_lat2();
        logic       md_t[5]   = '{1, 1, 1, 0, 0};
        logic [6:0] code_t[5] = '{C_MD, C_DONE, C_MD, C_DONE, C_DEF};
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); drive(md_t[k], 1'b0, 0);
            exp_q.push_back({code_t[k], 16'(exp_cnt_b)});
            #1; e = exp_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL md_lat2 cyc %0d got %h exp %h", k, obs_b, e); end
            if (!e.code[6]) exp_cnt_b++;
        end
    endtask

    task automatic test_saturation();
        reset_pulse();
        for (int k = 0; k < 22; k++) begin
            @(negedge clk); drive(1'b0, 1'b0, 1);
            exp_q.push_back({C_LU, 16'((k < 15) ? k : 15)});
            #1; e = exp_q.pop_front(); checks++;
            if (obs_c !== e) begin errors++; $display("FAIL saturate cyc %0d got %h exp %h", k, obs_c, e); end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_load_use();
        test_branch_over_load_use();
        test_back_to_back();
        test_reset_mid_md();
        test_md_lat2();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control sequencer for the 5-stage CPU. Sits beside the forwarding unit and drives the pipeline-register write enables and flushes.
- Handles three hazards: load-use stalls that forwarding cannot cover, taken-branch flushes resolved in EX, and multi-cycle MUL/DIV operations that hold EX for a fixed latency.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MD_LATENCY, 4, cycles a MUL/DIV instruction occupies EX (legal range 2..16)
CNT_W, 16, width of stall-cycle counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
ID_rs1_i  input  5  rs1 field (instr[19:15]) of instruction in ID
ID_rs2_i  input  5  rs2 field (instr[24:20]) of instruction in ID
ID_use_rs1_i  input  1  ID instruction reads rs1
ID_use_rs2_i  input  1  ID instruction reads rs2
EXE_rd_i  input  5  rd field (instr[11:7]) of instruction in EX
EXE_MemRead_i  input  1  EX instruction is a load
EXE_branch_taken_i  input  1  EX branch/jump resolved taken
EXE_md_valid_i  input  1  EX instruction is MUL/DIV
PC_write_o  output  1  PC update enable
IFID_write_o  output  1  IF/ID register write enable
IFID_flush_o  output  1  IF/ID register clear to NOP
IDEX_write_o  output  1  ID/EX register write enable
IDEX_flush_o  output  1  ID/EX register clear to bubble (WB/MEM controls = 0)
EXMEM_bubble_o  output  1  EX/MEM captures bubble instead of EX result
md_done_o  output  1  MUL/DIV result valid this cycle
stall_cycles_o  output  CNT_W  saturating count of cycles with PC_write_o = 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_i = 0):
  - state = RUN, md_cnt = 0, stall_cycles_o = 0.
  - All outputs 0, including the write enables, which freeze the pipeline.
  - Reset mid-MD_BUSY aborts the operation; no md_done_o pulse follows.
- State register: RUN, MD_BUSY. md_cnt is 4 bits.
- Control outputs are combinational from state, md_cnt and the current inputs; there is no added latency.
- Defaults (RUN, no hazard): PC_write_o = IFID_write_o = IDEX_write_o = 1; all flush/bubble/done outputs = 0.
- load_use = EXE_MemRead_i & (EXE_rd_i != 0) & ((ID_use_rs1_i & EXE_rd_i == ID_rs1_i) | (ID_use_rs2_i & EXE_rd_i == ID_rs2_i)).
- RUN, priority order:
  1. EXE_md_valid_i: PC_write_o = IFID_write_o = IDEX_write_o = 0, EXMEM_bubble_o = 1. Next state MD_BUSY, md_cnt <= MD_LATENCY-2. If branch_taken or load_use are asserted simultaneously, they are ignored.
  2. EXE_branch_taken_i: IFID_flush_o = 1, IDEX_flush_o = 1, PC_write_o = 1 (redirect). load_use is ignored because the dependent instruction is flushed.
  3. load_use: PC_write_o = 0, IFID_write_o = 0, IDEX_flush_o = 1. Exactly one bubble per occurrence, because the next cycle the load has moved to MEM.
- MD_BUSY:
  - md_cnt != 0: same stall outputs as the RUN start cycle; md_cnt decrements.
  - md_cnt == 0: md_done_o = 1, default enables (pipeline advances, result enters EX/MEM); next state RUN.
    - EXE_md_valid_i is ignored in this cycle, so the same instruction is not restarted.
    - Branch and load-use evaluation applies as in RUN.
- Total stall per MUL/DIV: MD_LATENCY-1 cycles. The instruction occupies EX for MD_LATENCY cycles.
- stall_cycles_o:
  - Increments on each clock edge where rst_i = 1 and PC_write_o = 0.
  - Holds at 2^CNT_W-1; no wrap.
- Branch flush and load-use both count as zero stall cycles for flush and one for load-use. Only PC_write_o = 0 counts.

Test Plan:
- Reset: rst_i low mid-run, with EXE_md_valid_i = 1 in MD_BUSY, md_cnt = 1 -> all outputs 0 immediately (asynchronous). Release -> RUN defaults (PC_write_o = 1). No md_done_o pulse.
- Load-use: EXE_MemRead_i = 1, EXE_rd_i = 5, ID_rs2_i = 5, ID_use_rs2_i = 1 -> exactly one cycle of PC_write_o = 0, IFID_write_o = 0, IDEX_flush_o = 1; stall_cycles_o 0 -> 1. Repeat with EXE_rd_i = 0 -> no stall.
- Branch over load-use: branch_taken = 1 together with a load_use condition -> IFID_flush_o = 1, IDEX_flush_o = 1, PC_write_o = 1, stall_cycles_o unchanged.
- MUL/DIV latency, MD_LATENCY = 4, EXE_md_valid_i held high for 4 cycles -> stall outputs in cycles 0-2, md_done_o = 1 only in cycle 3, stall_cycles_o = 3. Back-to-back MUL/DIV starts a new 4-cycle sequence in cycle 4.
- MD_LATENCY = 2 build -> one stall cycle, md_done_o in the second cycle.
- Saturation, CNT_W = 4 build: hold a load-use condition for 20 cycles -> stall_cycles_o reaches 15 and stays at 15.
